// File: rtl/roll_offset_generator.sv
// roll_offset_generator
//   Turns the 8-bit receiver roll channel into per-motor thrust offsets for a
//   quad-X airframe. The motor mixer adds these offsets to the base throttle.
//   Stick right of CENTER raises the left-side motors (1 = front-left,
//   3 = rear-left). Stick left of CENTER raises the right-side motors
//   (2 = front-right, 4 = rear-right).
//
//   Optional feature macro: ROLL_OFFSET_SLEW_EN.
//   When it is defined, each output moves toward its target by at most
//   SLEW_STEP per cycle. When it is undefined, the outputs are the targets
//   registered with one cycle of latency.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset; all outputs forced to 0
//   roll_rec_val   in   [7:0] unsigned roll command
//   motor_1_offset out  [7:0] front-left offset
//   motor_2_offset out  [7:0] front-right offset
//   motor_3_offset out  [7:0] rear-left offset
//   motor_4_offset out  [7:0] rear-right offset
module roll_offset_generator #(
    parameter int unsigned CENTER     = 128,
    parameter int unsigned DEADBAND   = 4,
    parameter int unsigned GAIN_SHIFT = 0,
    parameter int unsigned MAX_OFFSET = 255,
    parameter int unsigned SLEW_STEP  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] roll_rec_val,
    output logic [7:0] motor_1_offset,
    output logic [7:0] motor_2_offset,
    output logic [7:0] motor_3_offset,
    output logic [7:0] motor_4_offset
);

    localparam logic [8:0]  CenterW = 9'(CENTER);
    localparam logic [8:0]  DeadW   = 9'(DEADBAND);
    localparam logic [10:0] MaxW    = 11'(MAX_OFFSET);

    logic [8:0]  mag;
    logic        dir_right;
    logic [8:0]  eff;
    logic [10:0] scaled;
    logic [7:0]  target;
    logic [7:0]  tgt_left_d;   // motors 1 and 3
    logic [7:0]  tgt_right_d;  // motors 2 and 4
    logic [7:0]  left_q, left_d;
    logic [7:0]  right_q, right_d;

    // The magnitude never exceeds 254, so eff << 3 still fits in 11 bits.
    always_comb begin
        dir_right = 1'b0;
        mag       = '0;
        eff       = '0;
        scaled    = '0;
        target    = '0;
        if ({1'b0, roll_rec_val} >= CenterW) begin
            dir_right = 1'b1;
            mag       = {1'b0, roll_rec_val} - CenterW;
        end else begin
            mag       = CenterW - {1'b0, roll_rec_val};
        end
        if (mag > DeadW) begin
            eff = mag - DeadW;
        end
        scaled = {2'b00, eff} << GAIN_SHIFT;
        target = (scaled > MaxW) ? MaxW[7:0] : scaled[7:0];
        tgt_left_d  = dir_right ? target : 8'd0;
        tgt_right_d = dir_right ? 8'd0 : target;
    end

`ifdef ROLL_OFFSET_SLEW_EN
    localparam logic [7:0] StepW = 8'(SLEW_STEP);

    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        res = tgt;
        if (tgt > cur) begin
            if ((tgt - cur) > StepW) res = cur + StepW;
        end else if (cur > tgt) begin
            if ((cur - tgt) > StepW) res = cur - StepW;
        end
        return res;
    endfunction

    always_comb begin
        left_d  = slew(left_q, tgt_left_d);
        right_d = slew(right_q, tgt_right_d);
    end
`else
    always_comb begin
        left_d  = tgt_left_d;
        right_d = tgt_right_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q  <= '0;
            right_q <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Each motor pair shares a single register, so paired outputs stay equal.
    assign motor_1_offset = left_q;
    assign motor_3_offset = left_q;
    assign motor_2_offset = right_q;
    assign motor_4_offset = right_q;

endmodule

// File: tb/tb_roll_offset_generator.sv
// Self-checking bench for roll_offset_generator.
// The bench drives four instances from one shared stimulus:
//   default parameters, GAIN_SHIFT=1, GAIN_SHIFT=2, and MAX_OFFSET=100.
// A behavioural reference model tracks the expected value of every output.
module tb_roll_offset_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] roll = 8'd0;

    logic [7:0] m1 [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m4 [4];

    int gs_of [4] = '{0, 1, 2, 0};
    int mx_of [4] = '{255, 255, 255, 100};
    int exp_l [4];
    int exp_r [4];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    roll_offset_generator u_d0 (
        .clk(clk), .rst_n(rst_n), .roll_rec_val(roll),
        .motor_1_offset(m1[0]), .motor_2_offset(m2[0]),
        .motor_3_offset(m3[0]), .motor_4_offset(m4[0]));
    roll_offset_generator #(.GAIN_SHIFT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .roll_rec_val(roll),
        .motor_1_offset(m1[1]), .motor_2_offset(m2[1]),
        .motor_3_offset(m3[1]), .motor_4_offset(m4[1]));
    roll_offset_generator #(.GAIN_SHIFT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .roll_rec_val(roll),
        .motor_1_offset(m1[2]), .motor_2_offset(m2[2]),
        .motor_3_offset(m3[2]), .motor_4_offset(m4[2]));
    roll_offset_generator #(.MAX_OFFSET(100)) u_d3 (
        .clk(clk), .rst_n(rst_n), .roll_rec_val(roll),
        .motor_1_offset(m1[3]), .motor_2_offset(m2[3]),
        .motor_3_offset(m3[3]), .motor_4_offset(m4[3]));

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Reference: offsets for one instance, computed from the stick rules.
    task automatic model_target(input int val, input int inst, output int tl, output int tr);
        int mag;
        int eff;
        int t;
        bit right;
        right = (val >= 128);
        mag   = right ? val - 128 : 128 - val;
        eff   = (mag <= 4) ? 0 : mag - 4;
        t     = eff * (1 << gs_of[inst]);
        if (t > mx_of[inst]) t = mx_of[inst];
        tl = right ? t : 0;
        tr = right ? 0 : t;
    endtask

    function automatic int model_step(input int cur, input int tgt);
`ifdef ROLL_OFFSET_SLEW_EN
        if (tgt > cur + 8) return cur + 8;
        if (tgt < cur - 8) return cur - 8;
        return tgt;
`else
        return tgt;
`endif
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s[%0d].m1", tag, i), int'(m1[i]), exp_l[i]);
            check($sformatf("%s[%0d].m3", tag, i), int'(m3[i]), exp_l[i]);
            check($sformatf("%s[%0d].m2", tag, i), int'(m2[i]), exp_r[i]);
            check($sformatf("%s[%0d].m4", tag, i), int'(m4[i]), exp_r[i]);
        end
    endtask

    // Drive one value, clock it in, advance the model, and compare.
    task automatic apply(input int val, input string tag);
        int tl;
        int tr;
        roll = 8'(val);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            model_target(val, i, tl, tr);
            exp_l[i] = model_step(exp_l[i], tl);
            exp_r[i] = model_step(exp_r[i], tr);
        end
        check_all($sformatf("%s(v=%0d)", tag, val));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            exp_l[i] = 0;
            exp_r[i] = 0;
        end
    endtask

    initial begin
        clear_model();
        // Reset is held while the input sits at full left stick.
        roll = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Left-roll sweep from 0 to 40.
        for (int v = 0; v <= 40; v++) apply(v, "sweep");
`ifndef ROLL_OFFSET_SLEW_EN
        check("sweep_end_m2", int'(m2[0]), 84);
        check("sweep_end_m1", int'(m1[0]), 0);
`endif

        // Neutral position and the deadband edges.
        apply(124, "db");
        apply(128, "db");
        apply(132, "db");
        apply(133, "db");
        apply(123, "db");
        apply(255, "rext");
        apply(200, "gain");
        apply(0, "sat");
`ifndef ROLL_OFFSET_SLEW_EN
        check("sat_gs2_m2", int'(m2[2]), 255);
        check("sat_max100_m2", int'(m2[3]), 100);
        check("lext_m2", int'(m2[0]), 124);
`endif

        // Randomized stimulus.
        for (int n = 0; n < 200; n++) apply(int'($urandom_range(0, 255)), "rand");

        // Mid-run reset: the outputs must clear without a clock edge.
        apply(0, "prerst");
        apply(0, "prerst");
        #3;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Step to full left, then reverse to full right.
        apply(128, "slew");
        for (int n = 0; n < 20; n++) apply(0, "slew_l");
        for (int n = 0; n < 20; n++) apply(255, "slew_r");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
